// File: rtl/vec_fp16_unit.sv
// vec_fp16_unit: multi-cycle FP16 vector add/sub/sum-reduce over a shared adder datapath.
module vec_fp16_unit #(
  parameter int LANES = 16,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [16*LANES-1:0]   op_1,
  input  logic [16*LANES-1:0]   op_2,
  output logic                  busy,
  output logic                  done,
  output logic [16*LANES-1:0]   result
);
  localparam int K = LANES / LANES_PER_CYCLE;
  localparam int CW = $clog2(LANES);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN_VEC = 2'd1;
  localparam logic [1:0] RUN_RED = 2'd2;

  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic sub;
  logic [15:0] acc;
  logic [16*LANES-1:0] a_reg, b_reg, buf_r, nxt_buf;
  logic [15:0] x [LANES_PER_CYCLE];
  logic [15:0] y [LANES_PER_CYCLE];
  logic [15:0] s [LANES_PER_CYCLE];
  logic red;

  // Truncating FP16 add: denormal inputs flush to zero, saturating overflow, signed-zero underflow.
  function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0] ea, eb, el, es, d;
    logic [10:0] ma, mb, ml, ms;
    logic [11:0] m;
    logic sl, ss, swap;
    logic signed [6:0] e;
    ea = a[14:10];
    eb = b[14:10];
    ma = (ea != 5'd0) ? {1'b1, a[9:0]} : 11'd0;
    mb = (eb != 5'd0) ? {1'b1, b[9:0]} : 11'd0;
    swap = {eb, mb} > {ea, ma};
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    ml = swap ? mb : ma;
    ms = swap ? ma : mb;
    sl = swap ? b[15] : a[15];
    ss = swap ? a[15] : b[15];
    d = el - es;
    ms = (d >= 5'd12) ? 11'd0 : ms >> d;
    m = (sl == ss) ? {1'b0, ml} + {1'b0, ms} : {1'b0, ml} - {1'b0, ms};
    e = $signed({2'b00, el});
    if (m[11]) begin
      m = m >> 1;
      e = e + 7'sd1;
    end else begin
      for (int i = 0; i < 11; i++)
        if (m != 12'd0 && !m[10]) begin
          m = m << 1;
          e = e - 7'sd1;
        end
    end
    return (m == 12'd0) ? 16'h0000 :
           (e > 7'sd30) ? {sl, 15'h7BFF} :
           (e < 7'sd1)  ? {sl, 15'h0000} : {sl, e[4:0], m[9:0]};
  endfunction

  function automatic int lane_of(input logic [CW-1:0] c, input int j);
    return (int'(c) * LANES_PER_CYCLE + j) % LANES;
  endfunction

  assign busy = state != IDLE;
  assign red = state == RUN_RED;

  // Lane 0's adder doubles as the reduction adder, fed acc and the current lane.
  always_comb begin
    nxt_buf = buf_r;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      x[j] = a_reg[16*lane_of(cnt, j) +: 16];
      y[j] = b_reg[16*lane_of(cnt, j) +: 16] ^ {sub, 15'h0000};
    end
    x[0] = red ? acc : x[0];
    y[0] = red ? a_reg[16*int'(cnt) +: 16] : y[0];
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      s[j] = fp_add(x[j], y[j]);
      nxt_buf[16*lane_of(cnt, j) +: 16] = s[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sub <= 1'b0;
      acc <= '0;
      a_reg <= '0;
      b_reg <= '0;
      buf_r <= '0;
      result <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !mode[1]) begin
            state <= RUN_VEC;
            cnt <= '0;
            sub <= mode[0];
            a_reg <= op_1;
            b_reg <= op_2;
          end else if (start && mode == 2'b10) begin
            state <= RUN_RED;
            cnt <= '0;
            acc <= '0;
            a_reg <= op_1;
          end
        end
        RUN_VEC: begin
          buf_r <= nxt_buf;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(K - 1)) begin
            state <= IDLE;
            result <= nxt_buf;
            done <= 1'b1;
          end
        end
        RUN_RED: begin
          acc <= s[0];
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LANES - 1)) begin
            state <= IDLE;
            result <= {{(16*(LANES-1)){1'b0}}, s[0]};
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vec_fp16_unit.sv
// tb_vec_fp16_unit: randomized self-checking bench against an integer-arithmetic FP16 model.
module tb_vec_fp16_unit;
  localparam int L = 16;
  localparam int P = 4;
  localparam int K = L / P;
  localparam int W = 16 * L;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] op_1 = '0;
  logic [W-1:0] op_2 = '0;
  logic busy, done;
  logic [W-1:0] result;
  int errors = 0;
  int checks = 0;

  vec_fp16_unit #(.LANES(L), .LANES_PER_CYCLE(P)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_1(op_1), .op_2(op_2),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, el, ml, ms, d, v, e;
    bit sl, ss, neg;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    if (ea * 2048 + ma >= eb * 2048 + mb) begin
      el = ea; ml = ma; sl = a[15]; ms = mb; ss = b[15]; d = ea - eb;
    end else begin
      el = eb; ml = mb; sl = b[15]; ms = ma; ss = a[15]; d = eb - ea;
    end
    ms = (d >= 12) ? 0 : ms >> d;
    v = (sl ? -ml : ml) + (ss ? -ms : ms);
    if (v == 0) return 16'h0000;
    neg = v < 0;
    v = neg ? -v : v;
    e = el;
    while (v >= 2048) begin v = v >> 1; e++; end
    while (v < 1024) begin v = v << 1; e--; end
    if (e > 30) return {neg, 15'h7BFF};
    if (e < 1) return {neg, 15'h0000};
    return {neg, 5'(e), 10'(v - 1024)};
  endfunction

  function automatic logic [W-1:0] ref_vec(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [15:0] acc;
    r = '0;
    acc = 16'h0000;
    for (int i = 0; i < L; i++) begin
      if (m == 2'b10) acc = m_add(acc, a[16*i +: 16]);
      else r[16*i +: 16] = m_add(a[16*i +: 16], b[16*i +: 16] ^ (m == 2'b01 ? 16'h8000 : 16'h0000));
    end
    if (m == 2'b10) r[15:0] = acc;
    return r;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic [4:0] e;
    e = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(12, 18));
    return {1'($urandom), e, 10'($urandom)};
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int i = 0; i < L; i++) v[16*i +: 16] = rnd_fp();
    return v;
  endfunction

  task automatic run_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b, output int cyc);
    @(negedge clk);
    start = 1'b1; mode = m; op_1 = a; op_2 = b;
    @(negedge clk);
    start = 1'b0; op_1 = rnd_vec(); op_2 = rnd_vec();
    cyc = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_vadd();
    logic [W-1:0] exp;
    exp = {L{16'h4200}};
    @(negedge clk);
    start = 1'b1; mode = 2'b00; op_1 = {L{16'h3C00}}; op_2 = {L{16'h4000}};
    for (int c = 0; c <= K; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== (c < K) || done !== (c == K)) begin
        errors++;
        $display("FAIL vadd_timing E+%0d busy=%b done=%b want %b %b", c, busy, done, c < K, c == K);
      end
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL vadd_result got=%h want=%h", result, exp);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL vadd_done_pulse done=%b result=%h want 0 %h", done, result, exp);
    end
  endtask

  task automatic test_vsub();
    logic [W-1:0] a, b;
    int cyc;
    a = {L{16'h3800}};
    b = {L{16'h3800}};
    a[15:0] = 16'h3C00; b[15:0] = 16'h3C00;
    a[31:16] = 16'h3C00; b[31:16] = 16'h4000;
    run_op(2'b01, a, b, cyc);
    checks++;
    if (cyc != K) begin
      errors++;
      $display("FAIL vsub_latency got=%0d want=%0d", cyc, K);
    end
    for (int i = 0; i < L; i++) begin
      checks++;
      if (result[16*i +: 16] !== (i == 1 ? 16'hBC00 : 16'h0000)) begin
        errors++;
        $display("FAIL vsub_lane%0d got=%h want=%h", i, result[16*i +: 16], i == 1 ? 16'hBC00 : 16'h0000);
      end
    end
  endtask

  task automatic test_vred();
    logic [W-1:0] exp;
    int cyc;
    exp = '0;
    exp[15:0] = 16'h4C00;
    run_op(2'b10, {L{16'h3C00}}, rnd_vec(), cyc);
    checks++;
    if (cyc != L) begin
      errors++;
      $display("FAIL vred_latency got=%0d want=%0d", cyc, L);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL vred_result got=%h want=%h", result, exp);
    end
  endtask

  task automatic test_edge();
    logic [W-1:0] a, b;
    logic [15:0] ea [4] = '{16'h7BFF, 16'h3C00, 16'h0123, 16'h3E00};
    logic [15:0] eb [4] = '{16'h7BFF, 16'h1000, 16'h3C00, 16'hBC00};
    logic [15:0] er [4] = '{16'h7BFF, 16'h3C00, 16'h3C00, 16'h3800};
    int cyc;
    a = rnd_vec();
    b = rnd_vec();
    for (int i = 0; i < 4; i++) begin
      a[16*i +: 16] = ea[i];
      b[16*i +: 16] = eb[i];
    end
    run_op(2'b00, a, b, cyc);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (result[16*i +: 16] !== er[i]) begin
        errors++;
        $display("FAIL edge_case%0d got=%h want=%h", i, result[16*i +: 16], er[i]);
      end
    end
    checks++;
    if (result !== ref_vec(2'b00, a, b)) begin
      errors++;
      $display("FAIL edge_vector got=%h want=%h", result, ref_vec(2'b00, a, b));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [1:0] m;
    int cyc;
    for (int n = 0; n < 24; n++) begin
      m = 2'($urandom_range(0, 2));
      a = rnd_vec();
      b = rnd_vec();
      run_op(m, a, b, cyc);
      checks++;
      if (cyc != (m == 2'b10 ? L : K) || result !== ref_vec(m, a, b)) begin
        errors++;
        $display("FAIL random%0d mode=%0d cyc=%0d got=%h want=%h", n, m, cyc, result, ref_vec(m, a, b));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] a, b;
    int cyc, pulses;
    a = rnd_vec();
    b = rnd_vec();
    @(negedge clk);
    start = 1'b1; mode = 2'b00; op_1 = a; op_2 = b;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'b10; op_1 = rnd_vec(); op_2 = rnd_vec();
    @(negedge clk);
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != K || result !== ref_vec(2'b00, a, b)) begin
      errors++;
      $display("FAIL busy_ignore cyc=%0d got=%h want=%h", cyc, result, ref_vec(2'b00, a, b));
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(done);
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_extra pulses=%0d busy=%b want 0 0", pulses, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    int cyc;
    a1 = rnd_vec(); b1 = rnd_vec(); a2 = rnd_vec(); b2 = rnd_vec();
    run_op(2'b00, a1, b1, cyc);
    start = 1'b1; mode = 2'b01; op_1 = a2; op_2 = b2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || result !== ref_vec(2'b00, a1, b1)) begin
      errors++;
      $display("FAIL b2b_accept busy=%b got=%h want=%h", busy, result, ref_vec(2'b00, a1, b1));
    end
    cyc = 0;
    while (!done && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != K || result !== ref_vec(2'b01, a2, b2)) begin
      errors++;
      $display("FAIL b2b_second cyc=%0d got=%h want=%h", cyc, result, ref_vec(2'b01, a2, b2));
    end
  endtask

  task automatic test_mode11();
    int hits;
    hits = 0;
    @(negedge clk);
    start = 1'b1; mode = 2'b11; op_1 = rnd_vec();
    repeat (3) begin
      @(negedge clk);
      hits += int'(busy) + int'(done);
    end
    start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      hits += int'(busy) + int'(done);
    end
    checks++;
    if (hits != 0) begin
      errors++;
      $display("FAIL mode11 busy/done cycles=%0d want 0", hits);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    int cyc, pulses;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; op_1 = rnd_vec(); op_2 = rnd_vec();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h want 0 0 0", busy, done, result);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(done);
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done pulses=%0d want 0", pulses);
    end
    a = rnd_vec();
    b = rnd_vec();
    run_op(2'b00, a, b, cyc);
    checks++;
    if (cyc != K || result !== ref_vec(2'b00, a, b)) begin
      errors++;
      $display("FAIL reset_mid_restart cyc=%0d got=%h want=%h", cyc, result, ref_vec(2'b00, a, b));
    end
  endtask

  initial begin
    test_reset();
    test_vadd();
    test_vsub();
    test_vred();
    test_edge();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_mode11();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vec_fp16_unit.md
# vec_fp16_unit

Multi-cycle, parametrised FP16 vector arithmetic unit: successor to the single-cycle VADD path in the ALU. Processes a packed vector of LANES half-precision elements, LANES_PER_CYCLE lanes per clock, through a shared adder datapath. Supports element-wise add, element-wise subtract, and a sequential sum-reduction, with a start/busy/done handshake to the issue stage.

## Interface
- LANES, 16: elements per vector; even, ≥2.
- LANES_PER_CYCLE, 4: lanes processed per clock in VADD/VSUB; must divide LANES.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- mode  in  2  00 VADD, 01 VSUB, 10 VRED, 11 reserved.
- op_1  in  16*LANES  operand A; lane i = op_1[16*i +: 16].
- op_2  in  16*LANES  operand B; ignored in VRED.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- result  out  16*LANES  registered result; lane i = result[16*i +: 16].

## Operation
- Format: sign [15], exponent [14:10] (bias 15), mantissa [9:0], hidden 1 when exponent≠0.
- Exponent 0 on input: operand is zero (denormals flushed); exponent 31 treated as an ordinary finite exponent.
- Add rule (per lane): take magnitudes with hidden bit; shift smaller-exponent mantissa right by exponent difference (difference ≥12 → contribution 0); add if signs equal, else subtract smaller magnitude from larger, sign of larger (equal magnitude → +0).
- Normalise: carry-out → shift right 1, exponent+1; leading zeros → shift left, exponent decremented per shift.
- Rounding: truncation (toward zero) at every shift.
- Overflow (exponent >30 after normalise): saturate to sign|0x7BFF. Underflow (exponent <1): signed zero.
- VSUB: op_2 lane sign inverted, then add rule.
- VRED: accumulator = +0, then acc = acc + op_1 lane k for k = 0..LANES-1 in order; result lane 0 = acc, lanes 1..LANES-1 = 0.
- Operands latched in internal registers on accept; op_1/op_2 may change afterwards.
- States: IDLE, RUN_VEC, RUN_RED.
  - IDLE: start=1 & mode∈{00,01} → RUN_VEC, chunk=0; mode 10 → RUN_RED, lane=0, acc=0; mode 11 → start ignored, stay IDLE.
  - RUN_VEC: each edge computes lanes [chunk*LPC +: LPC] into buffer; last chunk (K−1, K=LANES/LANES_PER_CYCLE) → IDLE.
  - RUN_RED: each edge adds lane into acc; lane LANES−1 → IDLE.
- result loaded as a whole on the completing edge; holds until the next completion. Never partially visible.
- start while busy=1 ignored (no queueing).

## Timing
- Reset: busy=0, done=0, result=0, state IDLE, internal buffers/acc cleared; reset mid-operation aborts with no done pulse.
- Accept at edge E (start=1, busy=0, valid mode): busy=1 after E.
- VADD/VSUB: done=1 and result valid after edge E+K; busy=0 after E+K. Default latency 4 cycles.
- VRED: done=1, result valid after edge E+LANES; default 16 cycles.
- done high exactly one cycle; deasserts on next edge.
- Back-to-back: start asserted during the done cycle is accepted (busy=0); next done K (or LANES) cycles later; result from first op holds until then.
- Throughput: one vector per K+0 cycles idle gap-free (accept edge coincides with completion-visible cycle).

## Test plan
- VADD all lanes 0x3C00 + 0x4000 (1.0+2.0) → done at E+4, every lane 0x4200; busy high exactly cycles E+1..E+4.
- VSUB lane0 0x3C00−0x3C00, lane1 0x3C00−0x4000, others 0x3800−0x3800 → lane0 0x0000, lane1 0xBC00, others 0x0000.
- VRED op_1 all 0x3C00 → done at E+16, lane0 0x4C00 (16.0), lanes 1..15 0x0000; op_2 random, no effect.
- Edge arithmetic: 0x7BFF+0x7BFF → 0x7BFF; 0x3C00+0x1000 → 0x3C00 (truncated); 0x0123+0x3C00 → 0x3C00 (denormal flushed); 0x3E00+0xBC00 → 0x3800.
- Handshake: start re-asserted while busy with changed operands → ignored, first result intact; start in done cycle → second op accepted, done 4 cycles later; mode 11 → no busy, no done.
- Reset at E+2 of VADD → busy, done, result 0 immediately (async); no done pulse afterwards; new start works normally.
